// File: rtl/bus_conv_pkg.sv
// Shared definitions for the 16<->48 bus converters: lane geometry,
// buffered word layout and the mty decode.
package bus_conv_pkg;

    localparam int unsigned LANE_W  = 16;
    localparam int unsigned LANES   = 3;
    localparam int unsigned WORD_W  = LANE_W * LANES;
    localparam int unsigned MTY_W   = 3;
    localparam int unsigned ENTRY_W = WORD_W + MTY_W + 2;
    localparam int unsigned CNT_W   = 2;

    // Bit positions of a buffered word: {sop, eop, mty, data}
    localparam int unsigned SOP_BIT = 52;
    localparam int unsigned EOP_BIT = 51;
    localparam int unsigned MTY_HI  = 50;
    localparam int unsigned MTY_LO  = 48;

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [MTY_W-1:0]   mty;
        logic [WORD_W-1:0]  data;
    } entry_t;

    // Index of the last valid lane in a word; mty[0] carries no meaning and
    // mty=6/7 collapses to a single lane.
    function automatic logic [CNT_W-1:0] last_lane(input logic eop,
                                                    input logic [MTY_W-1:0] mty);
        logic [CNT_W-1:0] idx;
        idx = CNT_W'(LANES - 1);
        if (eop) begin
            casez (mty)
                3'b00?:  idx = 2'd2;
                3'b01?:  idx = 2'd1;
                default: idx = 2'd0;
            endcase
        end
        return idx;
    endfunction

    // Lane 0 sits in the most significant 16 bits.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] data,
                                                   input logic [CNT_W-1:0] idx);
        logic [LANE_W-1:0] lane;
        case (idx)
            2'd0:    lane = data[47:32];
            2'd1:    lane = data[31:16];
            default: lane = data[15:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the oldest entry.
module sync_fifo #(
    parameter int unsigned DATA_W = 53,
    parameter int unsigned DEPT   = 4,
    parameter int unsigned DEPT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [DEPT_W:0]   usedw
);

    logic [DATA_W-1:0] mem [DEPT];
    logic [DEPT_W-1:0] wr_ptr;
    logic [DEPT_W-1:0] rd_ptr;
    logic [DEPT_W:0]   count;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + DEPT_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + DEPT_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (DEPT_W+1)'(1);
                2'b01:   count <= count - (DEPT_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (DEPT_W+1)'(DEPT));
    assign empty = (count == '0);
    assign usedw = count;

endmodule

// File: rtl/bus_conv_48_to_16.sv
// Re-serialises framed 48-bit packet words into a 16-bit pixel stream,
// filtering framing errors on the way in and trimming the eop word by mty.
module bus_conv_48_to_16
    import bus_conv_pkg::*;
#(
    parameter int unsigned DEPT   = 4,
    parameter int unsigned DEPT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [MTY_W-1:0]  din_mty,
    output logic              din_rdy,
    output logic [LANE_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    input  logic              dout_rdy,
    output logic              err
);

    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DEPT_W:0]    usedw;
    logic [DEPT_W:0]    usedw_nxt;
    entry_t             head;

    logic               in_pkt;
    logic               in_pkt_nxt;
    logic               err_nxt;
    logic               accept;
    logic               push;
    logic               wr_en;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   last;
    logic               at_last;
    logic               load;
    logic               pop;
    logic [LANE_W-1:0]  dout_nxt;
    logic               vld_nxt;
    logic               sop_nxt;
    logic               eop_nxt;
    logic               rdy_nxt;

    assign accept = din_vld && din_rdy;
    assign wr_en  = push && !fifo_full;
    assign head   = entry_t'(fifo_rdata);

    // Pack the incoming word with its framing into the buffer layout
    always_comb begin
        wdata                 = '0;
        wdata[SOP_BIT]        = din_sop;
        wdata[EOP_BIT]        = din_eop;
        wdata[MTY_HI:MTY_LO]  = din_mty;
        wdata[WORD_W-1:0]     = din;
    end

    // Framing filter: decide whether an accepted word is stored and flag errors
    always_comb begin
        push       = 1'b0;
        in_pkt_nxt = in_pkt;
        err_nxt    = 1'b0;
        if (accept) begin
            if (din_sop) begin
                push       = 1'b1;
                err_nxt    = in_pkt;
                in_pkt_nxt = !din_eop;
            end else if (!in_pkt) begin
                err_nxt    = 1'b1;
            end else begin
                push       = 1'b1;
                if (din_eop) in_pkt_nxt = 1'b0;
            end
            if (push && din_eop && (din_mty[2:1] == 2'b11)) err_nxt = 1'b1;
        end
    end

    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPT   (DEPT),
        .DEPT_W (DEPT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_en),
        .wdata (wdata),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .usedw (usedw)
    );

    assign last    = last_lane(head.eop, head.mty);
    assign at_last = (cnt >= last);
    assign load    = !dout_vld || dout_rdy;

    // Lane walker: load the next pixel whenever the output slot is free
    always_comb begin
        pop      = 1'b0;
        cnt_nxt  = cnt;
        dout_nxt = dout;
        vld_nxt  = dout_vld;
        sop_nxt  = dout_sop;
        eop_nxt  = dout_eop;
        if (load) begin
            if (!fifo_empty) begin
                dout_nxt = lane_sel(head.data, cnt);
                vld_nxt  = 1'b1;
                sop_nxt  = head.sop && (cnt == '0);
                eop_nxt  = head.eop && at_last;
                if (at_last) begin
                    pop     = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else begin
                vld_nxt = 1'b0;
            end
        end
    end

    // Ready for the next cycle follows the occupancy after this cycle's push/pop
    always_comb begin
        usedw_nxt = usedw + (DEPT_W+1)'(wr_en) - (DEPT_W+1)'(pop);
        rdy_nxt   = (usedw_nxt != (DEPT_W+1)'(DEPT));
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_pkt   <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            din_rdy  <= 1'b0;
        end else begin
            in_pkt   <= in_pkt_nxt;
            err      <= err_nxt;
            cnt      <= cnt_nxt;
            dout     <= dout_nxt;
            dout_vld <= vld_nxt;
            dout_sop <= sop_nxt;
            dout_eop <= eop_nxt;
            din_rdy  <= rdy_nxt;
        end
    end

endmodule

// File: tb/tb_bus_conv_48_to_16.sv
// Directed bench for the 48-to-16 packet re-serialiser.
module tb_bus_conv_48_to_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] din = '0;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [2:0]  din_mty = '0;
    logic        din_rdy;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_rdy = 1'b1;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [17:0] got[$];
    int          err_cnt = 0;
    int          stab_err = 0;
    bit          rdy_low_seen = 1'b0;
    bit          bp_en = 1'b0;
    int          ph = 0;
    logic [3:0]  pat = 4'b1001;
    logic        hold_prev = 1'b0;
    logic [18:0] prev_out = '0;

    always #5 clk = ~clk;

    bus_conv_48_to_16 #(.DEPT(4), .DEPT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .din_mty  (din_mty),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_rdy (dout_rdy),
        .err      (err)
    );

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && hold_prev && ({dout_vld, dout_sop, dout_eop, dout} !== prev_out))
            stab_err++;
        hold_prev = dout_vld && !dout_rdy && rst_n;
        prev_out  = {dout_vld, dout_sop, dout_eop, dout};
        if (rst_n && dout_vld && dout_rdy) got.push_back({dout_sop, dout_eop, dout});
        if (err) err_cnt++;
        if (rst_n && !din_rdy) rdy_low_seen = 1'b1;
    end

    // Downstream ready: pattern 1-0-0-1 while back-pressure is enabled
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            dout_rdy = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            dout_rdy = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [47:0] d, input logic s, input logic e, input logic [2:0] m);
        int   guard;
        logic acc;
        guard = 0;
        acc = 1'b0;
        din = d; din_sop = s; din_eop = e; din_mty = m; din_vld = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = din_rdy;
            @(posedge clk);
            #1;
            guard++;
        end
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = '0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout word=%h din_rdy never high", d);
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (din_rdy !== 1'b0) begin failures++; $display("FAIL reset_din_rdy got=%b exp=0", din_rdy); end
        checks++; if (dout_vld !== 1'b0) begin failures++; $display("FAIL reset_dout_vld got=%b exp=0", dout_vld); end
        checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        checks++; if ({dout_sop, dout_eop} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {dout_sop, dout_eop}); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
        tick(1);
        checks++; if (din_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy_after got=%b exp=1", din_rdy); end
    endtask

    task automatic test_two_word();
        logic [17:0] exp_q[$];
        logic [17:0] g;
        int e0;
        got.delete();
        e0 = err_cnt;
        send(48'h1111_2222_3333, 1'b1, 1'b0, 3'd0);
        checks++; if (dout_vld !== 1'b0) begin failures++; $display("FAIL latency_n1 dout_vld got=%b exp=0", dout_vld); end
        send(48'h4444_5555_6666, 1'b0, 1'b1, 3'd0);
        checks++; if ({dout_vld, dout_sop, dout} !== {2'b11, 16'h1111}) begin
            failures++; $display("FAIL latency_n2 got vld=%b sop=%b dout=%h exp 1 1 1111", dout_vld, dout_sop, dout);
        end
        tick(12);
        exp_q = '{{2'b10, 16'h1111}, {2'b00, 16'h2222}, {2'b00, 16'h3333},
                  {2'b00, 16'h4444}, {2'b00, 16'h5555}, {2'b01, 16'h6666}};
        checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL two_word_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 18'h3ffff;
            checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL two_word_px%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL two_word_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_mty();
        logic [17:0] exp_q[$];
        logic [17:0] g;
        int e0;
        got.delete();
        e0 = err_cnt;
        send(48'h1111_2222_3333, 1'b1, 1'b0, 3'd0);
        send(48'hAAAA_BBBB_CCCC, 1'b0, 1'b1, 3'd2);
        send(48'hAAAA_BBBB_CCCC, 1'b1, 1'b1, 3'd4);
        send(48'hAAAA_BBBB_CCCC, 1'b1, 1'b1, 3'd6);
        tick(16);
        exp_q = '{{2'b10, 16'h1111}, {2'b00, 16'h2222}, {2'b00, 16'h3333},
                  {2'b00, 16'hAAAA}, {2'b01, 16'hBBBB},
                  {2'b11, 16'hAAAA}, {2'b11, 16'hAAAA}};
        checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL mty_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 18'h3ffff;
            checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL mty_px%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL mty6_err got=%0d exp=1", err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] g;
        logic [17:0] e;
        logic [15:0] b;
        int e0;
        got.delete();
        e0 = err_cnt;
        rdy_low_seen = 1'b0;
        stab_err = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 16'(16'h1000 + 3 * i);
            send({b, b + 16'd1, b + 16'd2}, (i == 0), (i == 7), 3'd0);
        end
        tick(80);
        bp_en = 1'b0;
        tick(4);
        checks++; if (got.size() !== 24) begin failures++; $display("FAIL b2b_count got=%0d exp=24", got.size()); end
        for (int k = 0; k < 24; k++) begin
            g = (k < got.size()) ? got[k] : 18'h3ffff;
            e = {(k == 0), (k == 23), 16'(16'h1000 + k)};
            checks++; if (g !== e) begin failures++; $display("FAIL b2b_px%0d got=%h exp=%h", k, g, e); end
        end
        checks++; if (rdy_low_seen !== 1'b1) begin failures++; $display("FAIL b2b_din_rdy_low got=%b exp=1", rdy_low_seen); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL b2b_stable got=%0d exp=0", stab_err); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_stray();
        logic [17:0] exp_q[$];
        logic [17:0] g;
        int e0;
        got.delete();
        e0 = err_cnt;
        send(48'hDEAD_BEEF_CAFE, 1'b0, 1'b0, 3'd0);
        tick(6);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL stray_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (got.size() !== 0) begin failures++; $display("FAIL stray_dout got=%0d exp=0", got.size()); end
        send(48'h0102_0304_0506, 1'b1, 1'b1, 3'd0);
        tick(8);
        exp_q = '{{2'b10, 16'h0102}, {2'b00, 16'h0304}, {2'b01, 16'h0506}};
        checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL stray_next_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 18'h3ffff;
            checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL stray_px%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL stray_err_once got=%0d exp=1", err_cnt - e0); end
    endtask

    task automatic test_sop_mid();
        logic [17:0] exp_q[$];
        logic [17:0] g;
        int e0;
        got.delete();
        e0 = err_cnt;
        send(48'h7777_8888_9999, 1'b1, 1'b0, 3'd0);
        send(48'h4321_8765_CBA9, 1'b1, 1'b1, 3'd0);
        tick(12);
        exp_q = '{{2'b10, 16'h7777}, {2'b00, 16'h8888}, {2'b00, 16'h9999},
                  {2'b10, 16'h4321}, {2'b00, 16'h8765}, {2'b01, 16'hCBA9}};
        checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL sop_mid_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 18'h3ffff;
            checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL sop_mid_px%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL sop_mid_err got=%0d exp=1", err_cnt - e0); end
    endtask

    task automatic test_mid_reset();
        logic [17:0] exp_q[$];
        logic [17:0] g;
        int e0;
        got.delete();
        send(48'h5555_6666_7777, 1'b1, 1'b0, 3'd0);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        checks++; if ({dout_vld, dout_sop, dout_eop} !== 3'b000) begin
            failures++; $display("FAIL mid_reset_flags got=%b exp=000", {dout_vld, dout_sop, dout_eop});
        end
        checks++; if (dout !== 16'h0) begin failures++; $display("FAIL mid_reset_dout got=%h exp=0000", dout); end
        checks++; if ({din_rdy, err} !== 2'b00) begin failures++; $display("FAIL mid_reset_rdy_err got=%b exp=00", {din_rdy, err}); end
        rst_n = 1'b1;
        got.delete();
        tick(1);
        e0 = err_cnt;
        send(48'h0A0A_0B0B_0C0C, 1'b1, 1'b0, 3'd0);
        send(48'h0D0D_0E0E_0F0F, 1'b0, 1'b1, 3'd4);
        tick(12);
        exp_q = '{{2'b10, 16'h0A0A}, {2'b00, 16'h0B0B}, {2'b00, 16'h0C0C}, {2'b01, 16'h0D0D}};
        checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL mid_reset_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 18'h3ffff;
            checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL mid_reset_px%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL mid_reset_err got=%0d exp=0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_mty();
        test_back_to_back();
        test_stray();
        test_sop_mid();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
